// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute stage: ALU control codes, aluop classes,
// R-type funct[3:0] codes and immediate-op codes.
package alu_exec_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_IMM   = 2'b11;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_NOR = 4'b0111;
  localparam logic [3:0] FN_SLT = 4'b1010;

  localparam logic [1:0] IMM_ADDI = 2'b00;
  localparam logic [1:0] IMM_ANDI = 2'b01;
  localparam logic [1:0] IMM_ORI  = 2'b10;
  localparam logic [1:0] IMM_SLTI = 2'b11;

endpackage

// File: rtl/alu_exec_unit_add32.sv
// Plain 32-bit adder; carry-out is dropped so the sum wraps modulo 2^32.
module add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with flags and the two PC
// adders, all captured in a single output register (one-cycle latency).
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [1:0]  immop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] pcplus4,
  output logic [31:0] branch_target
);

  // Valid semantics: in_valid qualifies every input for one edge; out_valid
  // marks the edge after. There is no ready, so a new operation is accepted
  // on every edge and the outputs hold whenever in_valid is low.

  logic [2:0]  ctrl_d, ctrl_q;
  logic [31:0] result_d, result_q;
  logic [31:0] pc4_d, pc4_q;
  logic [31:0] bt_d, bt_q;
  logic [31:0] br_offset;
  logic        valid_q, zero_q, neg_q;
  logic [1:0]  funct_unused;

  assign funct_unused = funct[5:4];

  always_comb begin
    ctrl_d = ALU_ADD;
    case (aluop)
      AOP_ADD: ctrl_d = ALU_ADD;
      AOP_SUB: ctrl_d = ALU_SUB;
      AOP_RTYPE: begin
        case (funct[3:0])
          FN_ADD:  ctrl_d = ALU_ADD;
          FN_SUB:  ctrl_d = ALU_SUB;
          FN_AND:  ctrl_d = ALU_AND;
          FN_OR:   ctrl_d = ALU_OR;
          FN_NOR:  ctrl_d = ALU_NOR;
          FN_SLT:  ctrl_d = ALU_SLT;
          default: ctrl_d = ALU_ADD;
        endcase
      end
      AOP_IMM: begin
        case (immop)
          IMM_ADDI: ctrl_d = ALU_ADD;
          IMM_ANDI: ctrl_d = ALU_AND;
          IMM_ORI:  ctrl_d = ALU_OR;
          IMM_SLTI: ctrl_d = ALU_SLT;
          default:  ctrl_d = ALU_ADD;
        endcase
      end
      default: ctrl_d = ALU_ADD;
    endcase
  end

  always_comb begin
    result_d = '0;
    case (ctrl_d)
      ALU_AND: result_d = a & b;
      ALU_OR:  result_d = a | b;
      ALU_ADD: result_d = a + b;
      ALU_SUB: result_d = a - b;
      ALU_NOR: result_d = ~(a | b);
      // Signed compare rather than the sign of a-b, so overflow cannot flip it.
      ALU_SLT: result_d = {31'd0, ($signed(a) < $signed(b))};
      default: result_d = '0;
    endcase
  end

  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  add32 u_pcplus4 (
    .a_i   (pc),
    .b_i   (32'd4),
    .sum_o (pc4_d)
  );

  add32 u_branch (
    .a_i   (pc4_d),
    .b_i   (br_offset),
    .sum_o (bt_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ctrl_q   <= '0;
      pc4_q    <= '0;
      bt_q     <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= (result_d == 32'd0);
        neg_q    <= result_d[31];
        ctrl_q   <= ctrl_d;
        pc4_q    <= pc4_d;
        bt_q     <= bt_d;
      end
    end
  end

  assign out_valid     = valid_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign neg           = neg_q;
  assign alu_ctrl      = ctrl_q;
  assign pcplus4       = pc4_q;
  assign branch_target = bt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases from the block's
// documented behaviour followed by randomized traffic against a reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [1:0]  immop;
  logic [31:0] a, b, pc;
  logic [15:0] imm16;
  logic        out_valid, zero, neg;
  logic [31:0] result, pcplus4, branch_target;
  logic [2:0]  alu_ctrl;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Model of what the output register should currently hold.
  logic        m_valid;
  logic [31:0] m_result, m_pc4, m_bt;
  logic [2:0]  m_ctrl;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .aluop         (aluop),
    .funct         (funct),
    .immop         (immop),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .imm16         (imm16),
    .out_valid     (out_valid),
    .result        (result),
    .zero          (zero),
    .neg           (neg),
    .alu_ctrl      (alu_ctrl),
    .pcplus4       (pcplus4),
    .branch_target (branch_target)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [1:0] im);
    logic [2:0] c;
    c = 3'b010;
    if (op == 2'b01) c = 3'b110;
    else if (op == 2'b10) begin
      if (fn[3:0] == 4'd2)       c = 3'b110;
      else if (fn[3:0] == 4'd4)  c = 3'b000;
      else if (fn[3:0] == 4'd5)  c = 3'b001;
      else if (fn[3:0] == 4'd7)  c = 3'b100;
      else if (fn[3:0] == 4'd10) c = 3'b111;
    end else if (op == 2'b11) begin
      if (im == 2'd1)      c = 3'b000;
      else if (im == 2'd2) c = 3'b001;
      else if (im == 2'd3) c = 3'b111;
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    r = 32'd0;
    if (c == 3'b000)      r = x & y;
    else if (c == 3'b001) r = x | y;
    else if (c == 3'b010) r = x + y;
    else if (c == 3'b110) r = x + ~y + 32'd1;
    else if (c == 3'b100) r = ~(x | y);
    // Flipping the sign bits turns signed order into unsigned order.
    else if (c == 3'b111) r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
    return r;
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [1:0] im, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] pcv, input logic [15:0] iv);
    logic [31:0] off;
    in_valid = v; aluop = op; funct = fn; immop = im;
    a = av; b = bv; pc = pcv; imm16 = iv;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_result = 32'd0; m_ctrl = 3'd0; m_pc4 = 32'd0; m_bt = 32'd0;
      exp_q.delete();
    end else begin
      m_valid = v;
      if (v) begin
        off      = {{16{iv[15]}}, iv} * 32'd4;
        m_ctrl   = ref_ctrl(op, fn, im);
        m_result = ref_alu(m_ctrl, av, bv);
        m_pc4    = pcv + 32'd4;
        m_bt     = pcv + 32'd4 + off;
        exp_q.push_back(m_result);
      end
    end
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (exp_q.size() == 0) check_eq("result_queue_empty", 32'd1, 32'd0);
      else check_eq("result", result, exp_q.pop_front());
    end else begin
      check_eq("result_hold", result, m_result);
    end
    check_eq("zero", {31'd0, zero}, {31'd0, (m_result == 32'd0)});
    check_eq("neg", {31'd0, neg}, {31'd0, m_result[31]});
    check_eq("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_ctrl});
    check_eq("pcplus4", pcplus4, m_pc4);
    check_eq("branch_target", branch_target, m_bt);
  endtask

  task automatic op_r(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] want, input string tag);
    step(1'b1, 2'b10, fn, 2'b00, av, bv, 32'h100, 16'h0004);
    check_eq(tag, result, want);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners[6];
    corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;
    m_valid = 1'b0; m_result = 32'd0; m_ctrl = 3'd0; m_pc4 = 32'd0; m_bt = 32'd0;
    // Transaction offered during reset must be dropped.
    step(1'b1, 2'b00, 6'd0, 2'd0, 32'd5, 32'd6, 32'h40, 16'h1);
    step(1'b1, 2'b00, 6'd0, 2'd0, 32'd5, 32'd6, 32'h40, 16'h1);
    check_eq("reset_zero", {31'd0, zero}, 32'd1);
    check_eq("reset_pcplus4", pcplus4, 32'd0);
    rst_n = 1'b1;

    op_r(6'h20, 32'hF, 32'h5, 32'h14, "r_add");
    op_r(6'h22, 32'hF, 32'h5, 32'h0A, "r_sub");
    op_r(6'h24, 32'hF, 32'h5, 32'h05, "r_and");
    op_r(6'h25, 32'hF, 32'h5, 32'h0F, "r_or");
    op_r(6'h27, 32'hF, 32'h5, 32'hFFFF_FFF0, "r_nor");
    check_eq("nor_neg", {31'd0, neg}, 32'd1);
    op_r(6'h2A, 32'hF, 32'h5, 32'h0, "r_slt_false");
    op_r(6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, "slt_extreme");
    op_r(6'h2A, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, "slt_extreme_rev");
    op_r(6'h08, 32'h3, 32'h4, 32'h7, "jr_as_add");
    op_r(6'h20, 32'hFFFF_FFFF, 32'h1, 32'h0, "add_wrap");
    check_eq("add_wrap_zero", {31'd0, zero}, 32'd1);
    step(1'b1, 2'b01, 6'h3F, 2'd3, 32'd7, 32'd7, 32'h0, 16'h0);
    check_eq("sub_equal_zero", {31'd0, zero}, 32'd1);

    step(1'b1, 2'b11, 6'd0, 2'd1, 32'h0000_F0F0, 32'h0000_00FF, 32'h0, 16'h0);
    check_eq("andi", result, 32'h0000_00F0);
    step(1'b1, 2'b11, 6'd0, 2'd2, 32'h0000_F0F0, 32'h0000_00FF, 32'h0, 16'h0);
    check_eq("ori", result, 32'h0000_F0FF);
    step(1'b1, 2'b11, 6'd0, 2'd3, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h0, 16'h0);
    check_eq("slti", result, 32'h0);

    step(1'b1, 2'b00, 6'd0, 2'd0, 32'd1, 32'd2, 32'h0000_0010, 16'hFFFE);
    check_eq("pc4_dir", pcplus4, 32'h14);
    check_eq("bt_back", branch_target, 32'h0C);
    step(1'b1, 2'b00, 6'd0, 2'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 16'h0001);
    check_eq("pc4_wrap", pcplus4, 32'h0);
    check_eq("bt_wrap", branch_target, 32'h4);

    // Valid gating: 1,0,1 with the gap cycle carrying different operands.
    step(1'b1, 2'b00, 6'd0, 2'd0, 32'd10, 32'd20, 32'h200, 16'h0);
    step(1'b0, 2'b01, 6'd0, 2'd0, 32'd99, 32'd1, 32'h300, 16'h8);
    check_eq("gap_hold", result, 32'd30);
    step(1'b1, 2'b01, 6'd0, 2'd0, 32'd50, 32'd8, 32'h400, 16'h0);
    check_eq("after_gap", result, 32'd42);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] fn;
      fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) :
           {2'b10, 4'(($urandom_range(0, 5) == 0) ? 0 : ($urandom_range(0, 4) == 0 ? 2 :
            ($urandom_range(0, 3) == 0 ? 4 : ($urandom_range(0, 2) == 0 ? 5 :
            ($urandom_range(0, 1) == 0 ? 7 : 10)))))};
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      step($urandom_range(0, 3) != 0, 2'($urandom), fn, 2'($urandom),
           pick_operand(), pick_operand(), $urandom, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
